// File: rtl/id_ex_if.sv
// Decode-to-execute stage bundle: valid/ready handshake plus the payload
// carried between decode/register-read and execute.
//   valid      producer -> consumer  entry valid
//   ready      consumer -> producer  consumer can accept
//   exc/mem/wb producer -> consumer  execute / memory / writeback control bundles
//   r1e/r2e    producer -> consumer  scalar operands
//   imm        producer -> consumer  immediate
//   r1v/r2v    producer -> consumer  vector operands (LANES*LANE_W bits)
//   dest       producer -> consumer  destination register index
//   dest_type  producer -> consumer  0 = scalar dest, 1 = vector dest
// Modports: master = producer side, slave = consumer side.
interface id_ex_if #(
   parameter int LANES    = 12,
   parameter int LANE_W   = 16,
   parameter int SCALAR_W = 21,
   parameter int EXC_W    = 5,
   parameter int MEM_W    = 4,
   parameter int WB_W     = 2,
   parameter int DEST_W   = 4
);
   logic                      valid;
   logic                      ready;
   logic [EXC_W-1:0]          exc;
   logic [MEM_W-1:0]          mem;
   logic [WB_W-1:0]           wb;
   logic [SCALAR_W-1:0]       r1e;
   logic [SCALAR_W-1:0]       r2e;
   logic [SCALAR_W-1:0]       imm;
   logic [LANES*LANE_W-1:0]   r1v;
   logic [LANES*LANE_W-1:0]   r2v;
   logic [DEST_W-1:0]         dest;
   logic                      dest_type;

   modport master (
      output valid, exc, mem, wb, r1e, r2e, imm, r1v, r2v, dest, dest_type,
      input  ready
   );
   modport slave (
      input  valid, exc, mem, wb, r1e, r2e, imm, r1v, r2v, dest, dest_type,
      output ready
   );
endinterface

// File: rtl/id_ex_stage_reg.sv
// Decode-to-execute pipeline register with valid/ready handshake, a 2-entry
// (main + skid) buffer, flush and NOP-bubble insertion. All state updates on
// the falling edge of clk; rst is synchronous, active-high.
// Ports:
//   clk, rst   stage clock (falling edge active), synchronous reset
//   flush      discard held and incoming entries
//   up         slave side of id_ex_if from decode; up.ready is registered
//   dn         master side of id_ex_if to execute; payload is registered,
//              exc/mem/wb forced to 0 while dn.valid = 0
//   stall_cnt, bubble_cnt  (only with ID_EX_PERF_CNT_EN defined) saturating
//              counters of stalled and empty-but-ready edges, cleared by rst only
// Optional feature macro: ID_EX_PERF_CNT_EN
module id_ex_stage_reg #(
   parameter int LANES    = 12,
   parameter int LANE_W   = 16,
   parameter int SCALAR_W = 21,
   parameter int EXC_W    = 5,
   parameter int MEM_W    = 4,
   parameter int WB_W     = 2,
   parameter int DEST_W   = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   id_ex_if.slave      up,
   id_ex_if.master     dn
`ifdef ID_EX_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] bubble_cnt
`endif
);
   localparam int VEC_W = LANES * LANE_W;
   localparam int PAY_W = EXC_W + MEM_W + WB_W + 3*SCALAR_W + 2*VEC_W + DEST_W + 1;

   logic [PAY_W-1:0] in_pay;
   logic [PAY_W-1:0] main_pay;
   logic [PAY_W-1:0] skid_pay;
   logic             main_v;
   logic             skid_v;
   logic             rdy_q;
   logic             accept;
   logic             fire;

   logic [EXC_W-1:0]    exc_q;
   logic [MEM_W-1:0]    mem_q;
   logic [WB_W-1:0]     wb_q;
   logic [SCALAR_W-1:0] r1e_q, r2e_q, imm_q;
   logic [VEC_W-1:0]    r1v_q, r2v_q;
   logic [DEST_W-1:0]   dest_q;
   logic                dest_type_q;

   assign in_pay = {up.exc, up.mem, up.wb, up.r1e, up.r2e, up.imm,
                    up.r1v, up.r2v, up.dest, up.dest_type};

   assign accept = up.valid && rdy_q;
   assign fire   = main_v && dn.ready;

   // rdy_q always mirrors !skid_v for the next cycle, so a full skid can
   // never coincide with an accept; the skid-drain branch therefore never
   // has an incoming entry to park.
   always_ff @(negedge clk) begin
      if (rst) begin
         main_v   <= 1'b0;
         skid_v   <= 1'b0;
         main_pay <= '0;
         skid_pay <= '0;
         rdy_q    <= 1'b1;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (!main_v || fire) begin
         if (skid_v) begin
            main_pay <= skid_pay;
            main_v   <= 1'b1;
            skid_v   <= 1'b0;
         end else begin
            main_v <= accept;
            if (accept) main_pay <= in_pay;
         end
         rdy_q <= 1'b1;
      end else if (accept) begin
         skid_pay <= in_pay;
         skid_v   <= 1'b1;
         rdy_q    <= 1'b0;
      end
   end

   assign {exc_q, mem_q, wb_q, r1e_q, r2e_q, imm_q,
           r1v_q, r2v_q, dest_q, dest_type_q} = main_pay;

   assign up.ready     = rdy_q;
   assign dn.valid     = main_v;
   // NOP bubble: control bundles zeroed when empty, data holds last value.
   assign dn.exc       = main_v ? exc_q : '0;
   assign dn.mem       = main_v ? mem_q : '0;
   assign dn.wb        = main_v ? wb_q  : '0;
   assign dn.r1e       = r1e_q;
   assign dn.r2e       = r2e_q;
   assign dn.imm       = imm_q;
   assign dn.r1v       = r1v_q;
   assign dn.r2v       = r2v_q;
   assign dn.dest      = dest_q;
   assign dn.dest_type = dest_type_q;

`ifdef ID_EX_PERF_CNT_EN
   always_ff @(negedge clk) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_v && !dn.ready && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
         if (!main_v && dn.ready && bubble_cnt != 32'hFFFF_FFFF)
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
   typedef struct packed {
      logic [4:0]   exc;
      logic [3:0]   mem;
      logic [1:0]   wb;
      logic [20:0]  r1e;
      logic [20:0]  r2e;
      logic [20:0]  imm;
      logic [191:0] r1v;
      logic [191:0] r2v;
      logic [3:0]   dest;
      logic         dt;
   } ent_t;

   logic clk = 1'b0;
   logic rst, flush;
   always #5 clk = ~clk;

   id_ex_if up_if ();
   id_ex_if dn_if ();
`ifdef ID_EX_PERF_CNT_EN
   logic [31:0] stall_cnt, bubble_cnt;
`endif

   id_ex_stage_reg dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .up    (up_if.slave),
      .dn    (dn_if.master)
`ifdef ID_EX_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   ent_t q[$];
   ent_t last;
   int   checks = 0;
   int   errors = 0;
   longint stall_m = 0, bubble_m = 0;
   ent_t ent_e;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t rnd_ent();
      ent_t e;
      e.exc = 5'($urandom); e.mem = 4'($urandom); e.wb = 2'($urandom);
      e.r1e = 21'($urandom); e.r2e = 21'($urandom); e.imm = 21'($urandom);
      for (int k = 0; k < 12; k++) begin
         e.r1v[k*16 +: 16] = 16'($urandom);
         e.r2v[k*16 +: 16] = 16'($urandom);
      end
      e.dest = 4'($urandom); e.dt = 1'($urandom);
      return e;
   endfunction

   function automatic ent_t mk(input int exc_val, input int tag);
      ent_t e;
      e.exc = 5'(exc_val); e.mem = 4'(tag + 1); e.wb = 2'(tag);
      e.r1e = 21'(tag * 1000 + 7); e.r2e = 21'(tag * 3 + 1); e.imm = 21'(tag + 100);
      for (int k = 0; k < 12; k++) begin
         e.r1v[k*16 +: 16] = 16'(k + tag);
         e.r2v[k*16 +: 16] = 16'(k * 2 + tag);
      end
      e.dest = 4'(tag); e.dt = 1'(tag);
      return e;
   endfunction

   task automatic drive(input logic v, input ent_t e);
      up_if.valid = v;
      up_if.exc = e.exc; up_if.mem = e.mem; up_if.wb = e.wb;
      up_if.r1e = e.r1e; up_if.r2e = e.r2e; up_if.imm = e.imm;
      up_if.r1v = e.r1v; up_if.r2v = e.r2v;
      up_if.dest = e.dest; up_if.dest_type = e.dt;
   endtask

   task automatic check_out();
      ent_t e;
      bit   v;
      v = (q.size() > 0);
      e = v ? q[0] : last;
      chk("out_valid", 256'(dn_if.valid), 256'(v));
      chk("in_ready", 256'(up_if.ready), 256'(q.size() < 2));
      chk("exc_out", 256'(dn_if.exc), v ? 256'(e.exc) : 256'(0));
      chk("mem_out", 256'(dn_if.mem), v ? 256'(e.mem) : 256'(0));
      chk("wb_out",  256'(dn_if.wb),  v ? 256'(e.wb)  : 256'(0));
      chk("r1e_out", 256'(dn_if.r1e), 256'(e.r1e));
      chk("r2e_out", 256'(dn_if.r2e), 256'(e.r2e));
      chk("imm_out", 256'(dn_if.imm), 256'(e.imm));
      chk("r1v_out", 256'(dn_if.r1v), 256'(e.r1v));
      chk("r2v_out", 256'(dn_if.r2v), 256'(e.r2v));
      chk("dest_out", 256'(dn_if.dest), 256'(e.dest));
      chk("dest_type_out", 256'(dn_if.dest_type), 256'(e.dt));
`ifdef ID_EX_PERF_CNT_EN
      chk("stall_cnt", 256'(stall_cnt), 256'(stall_m));
      chk("bubble_cnt", 256'(bubble_cnt), 256'(bubble_m));
`endif
   endtask

   // One falling edge with the currently driven inputs; the model is
   // advanced with those inputs and outputs are checked at the next rising edge.
   task automatic cyc();
      bit   acc, fr;
      ent_t nx;
      acc = up_if.valid && (q.size() < 2);
      fr  = (q.size() > 0) && dn_if.ready;
      nx  = '{up_if.exc, up_if.mem, up_if.wb, up_if.r1e, up_if.r2e, up_if.imm,
              up_if.r1v, up_if.r2v, up_if.dest, up_if.dest_type};
      if (rst) begin
         stall_m = 0; bubble_m = 0;
      end else begin
         if (q.size() > 0 && !dn_if.ready && stall_m < 64'hFFFF_FFFF) stall_m++;
         if (q.size() == 0 && dn_if.ready && bubble_m < 64'hFFFF_FFFF) bubble_m++;
      end
      if (rst) begin
         q.delete(); last = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (fr) void'(q.pop_front());
         if (acc) q.push_back(nx);
         if (q.size() > 0) last = q[0];
      end
      @(negedge clk);
      @(posedge clk);
      check_out();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; dn_if.ready = 1'b0;
      drive(1'b1, rnd_ent());
      @(posedge clk);
      // Reset with random inputs
      for (int i = 0; i < 2; i++) begin
         drive(1'($urandom), rnd_ent());
         dn_if.ready = 1'($urandom);
         flush = 1'($urandom);
         cyc();
      end
      chk("reset_r1v_zero", 256'(dn_if.r1v), 256'(0));
      rst = 1'b0; flush = 1'b0;

      // Streaming
      dn_if.ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, mk(i, i));
         cyc();
         chk("stream_exc", 256'(dn_if.exc), 256'(i));
      end
      drive(1'b0, rnd_ent());
      cyc();
      cyc();

      // Stall / skid
      dn_if.ready = 1'b0;
      drive(1'b1, mk(10, 20)); cyc();    // A -> main
      drive(1'b1, mk(11, 21)); cyc();    // B -> skid
      chk("skid_full_ready", 256'(up_if.ready), 256'(0));
      drive(1'b1, mk(12, 22)); cyc();    // C held upstream
      cyc();
      dn_if.ready = 1'b1;
      cyc();                             // A fires, B to main
      chk("after_A_exc", 256'(dn_if.exc), 256'(11));
      cyc();                             // B fires, C accepted
      chk("after_B_exc", 256'(dn_if.exc), 256'(12));
      drive(1'b0, rnd_ent());
      cyc();
      cyc();

      // Flush with main and skid full
      dn_if.ready = 1'b0;
      drive(1'b1, mk(13, 23)); cyc();
      drive(1'b1, mk(14, 24)); cyc();
      drive(1'b1, mk(15, 25)); flush = 1'b1; cyc();
      flush = 1'b0;
      chk("flush_valid", 256'(dn_if.valid), 256'(0));
      drive(1'b0, rnd_ent());
      dn_if.ready = 1'b1;
      cyc();
      cyc();

      // Bubble after E
      ent_e = mk(31, 26);
      drive(1'b1, ent_e); cyc();
      drive(1'b0, rnd_ent()); cyc();
      chk("bubble_exc", 256'(dn_if.exc), 256'(0));
      chk("bubble_r1e", 256'(dn_if.r1e), 256'(ent_e.r1e));

      // Random traffic with occasional flush
      for (int i = 0; i < 300; i++) begin
         drive(1'($urandom_range(0, 3) != 0), rnd_ent());
         dn_if.ready = 1'($urandom_range(0, 2) != 0);
         flush = 1'($urandom_range(0, 39) == 0);
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, rnd_ent());
      dn_if.ready = 1'b1;
      cyc();
      cyc();
      cyc();

`ifdef ID_EX_PERF_CNT_EN
      rst = 1'b1; cyc(); rst = 1'b0;
      dn_if.ready = 1'b0;
      drive(1'b1, mk(5, 27)); cyc();
      drive(1'b0, rnd_ent());
      for (int i = 0; i < 5; i++) cyc();
      dn_if.ready = 1'b1;
      for (int i = 0; i < 4; i++) cyc();
      chk("perf_stall5", 256'(stall_cnt), 256'(5));
      chk("perf_bubble3", 256'(bubble_cnt), 256'(3));
      dn_if.ready = 1'b0; flush = 1'b1; cyc(); flush = 1'b0;
      chk("perf_flush_stall", 256'(stall_cnt), 256'(5));
      chk("perf_flush_bubble", 256'(bubble_cnt), 256'(3));
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("perf_rst_stall", 256'(stall_cnt), 256'(0));
      chk("perf_rst_bubble", 256'(bubble_cnt), 256'(0));
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
